// File: rtl/kgp_risc_pkg.sv
// Shared constants and types for the kgp_risc core: PC/instruction widths,
// opcode field position, HALT encoding and the fetch state enum.
package kgp_risc_pkg;
    localparam int PC_W    = 10;
    localparam int INSTR_W = 32;
    localparam int OPC_HI  = 31;
    localparam int OPC_LO  = 29;
    localparam logic [2:0] HALT_OPCODE = 3'b111;

    typedef enum logic [1:0] {BOOT, RUN, HALT} fetch_state_t;
endpackage

// File: rtl/fetch_perf_ctr.sv
// Saturating 16-bit event counter; counts edges where inc is high, sticks at 16'hFFFF.
// Only instantiated by fetch_unit when FETCH_PERF_CNT_EN is defined.
module fetch_perf_ctr (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [15:0] count
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != 16'hFFFF)) begin
            count <= count + 16'd1;
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, drives sync imem, squashes on redirect, stops on HALT.
// Optional macro FETCH_PERF_CNT_EN adds perf_fetched / perf_squashed counters.
module fetch_unit
    import kgp_risc_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               PCSrc,
    input  logic [PC_W-1:0]    exNPC,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    if_pc,
    output logic               if_valid,
`ifdef FETCH_PERF_CNT_EN
    output logic [15:0]        perf_fetched,
    output logic [15:0]        perf_squashed,
`endif
    output logic               halted
);
    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] req_pc_q, req_pc_d;
    logic            req_v_q, req_v_d;
    logic            advance;
    logic            halt_hit;
    logic            redirect;

    assign advance   = !stall && (state_q != HALT);
    // While stalled the memory re-reads the held address so instr stays stable.
    assign imem_addr = advance ? pc_q : req_pc_q;
    assign instr     = imem_rdata;
    assign if_pc     = req_pc_q;
    assign if_valid  = req_v_q;
    assign halted    = (state_q == HALT);

    assign redirect  = (state_q == RUN) && PCSrc;
    assign halt_hit  = req_v_q && (imem_rdata[OPC_HI:OPC_LO] == HALT_OPCODE)
                       && !stall && !PCSrc;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        req_v_d  = req_v_q;
        unique case (state_q)
            BOOT: begin
                if (!stall) begin
                    req_pc_d = RESET_PC;
                    req_v_d  = 1'b1;
                    pc_d     = RESET_PC + PC_W'(1);
                    state_d  = RUN;
                end
            end
            RUN: begin
                // Redirect beats both HALT and stall; the in-flight word is wrong-path.
                if (PCSrc) begin
                    pc_d    = exNPC;
                    req_v_d = 1'b0;
                end else if (halt_hit) begin
                    state_d = HALT;
                    req_v_d = 1'b0;
                end else if (!stall) begin
                    req_pc_d = pc_q;
                    req_v_d  = 1'b1;
                    pc_d     = pc_q + PC_W'(1);
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= BOOT;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
            req_v_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            req_v_q  <= req_v_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    fetch_perf_ctr u_fetched (
        .clk   (clk),
        .rst   (rst),
        .inc   (req_v_q && !stall),
        .count (perf_fetched)
    );

    fetch_perf_ctr u_squashed (
        .clk   (clk),
        .rst   (rst),
        .inc   (redirect),
        .count (perf_squashed)
    );
`else
    logic unused_redirect;
    assign unused_redirect = redirect;
`endif
endmodule
